// File: rtl/uart_bus_bridge.sv
// UART-to-peripheral-bus initiator: decodes serial W/R command frames, performs
// one bus beat while granted, and replies with an acknowledge or the read data.
module uart_bus_bridge #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned TIMEOUT_CLKS = 2_000_000
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        rxd,
    output logic        txd,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        rd,
    output logic        wr,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        busy
);

    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CLKS + 1);
    localparam int unsigned HALF   = CLKS_PER_BIT / 2;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] REPLY_ACK = 8'h4B;
    localparam logic [7:0] REPLY_ERR = 8'h3F;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {C_IDLE, C_ADDR, C_DATA, C_REQ, C_ACCESS, C_RESP, C_ERR} cmd_state_t;

    // receiver state
    rx_state_t        rx_state;
    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             byte_valid;
    logic             frame_err;

    // transmitter state
    tx_state_t        tx_state;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_shift;
    logic [23:0]      tx_rest;
    logic [1:0]       tx_left;

    // command state
    cmd_state_t       cmd_state;
    logic             is_write;
    logic [1:0]       byte_cnt;
    logic [TO_W-1:0]  to_cnt;

    logic             tx_load_c;
    logic [7:0]       tx_first_c;
    logic [1:0]       tx_count_c;
    logic             tx_done_c;

    // Reply source: read data (MSB byte first), write acknowledge, or error marker.
    always_comb begin
        tx_load_c  = 1'b0;
        tx_first_c = REPLY_ERR;
        tx_count_c = 2'd0;
        if (cmd_state == C_ACCESS) begin
            tx_load_c = 1'b1;
            if (is_write) begin
                tx_first_c = REPLY_ACK;
            end else begin
                tx_first_c = rdata[31:24];
                tx_count_c = 2'd3;
            end
        end else if (cmd_state == C_ERR) begin
            tx_load_c = 1'b1;
        end
    end

    assign tx_done_c = (tx_state == TX_STOP) && (tx_cnt == CNT_W'(CLKS_PER_BIT - 1)) &&
                       (tx_left == 2'd0);

    // Serial receiver: synchronize, find start edge, sample mid-bit, check stop.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rxd;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == CNT_W'(HALF - 1)) begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (rx_bit == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_bit <= rx_bit + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Serial transmitter: sends 1 or 4 bytes back-to-back, start bit on the load edge.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            txd      <= 1'b1;
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_rest  <= '0;
            tx_left  <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    txd <= 1'b1;
                    if (tx_load_c) begin
                        tx_shift <= tx_first_c;
                        tx_rest  <= rdata[23:0];
                        tx_left  <= tx_count_c;
                        tx_cnt   <= '0;
                        txd      <= 1'b0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        txd      <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            txd      <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            txd      <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_bit   <= tx_bit + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        tx_cnt <= '0;
                        if (tx_left != 2'd0) begin
                            tx_shift <= tx_rest[23:16];
                            tx_rest  <= {tx_rest[15:0], 8'h00};
                            tx_left  <= tx_left - 2'd1;
                            txd      <= 1'b0;
                            tx_state <= TX_START;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // Command FSM: frame decode, inter-byte timeout, bus handshake and reply sequencing.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            cmd_state <= C_IDLE;
            is_write  <= 1'b0;
            byte_cnt  <= '0;
            to_cnt    <= '0;
            bus_req   <= 1'b0;
            rd        <= 1'b0;
            wr        <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            busy      <= 1'b0;
        end else begin
            case (cmd_state)
                C_IDLE: begin
                    if (byte_valid) begin
                        busy     <= 1'b1;
                        byte_cnt <= '0;
                        to_cnt   <= '0;
                        if (rx_shift == CMD_WRITE || rx_shift == CMD_READ) begin
                            is_write  <= (rx_shift == CMD_WRITE);
                            cmd_state <= C_ADDR;
                        end else begin
                            cmd_state <= C_ERR;
                        end
                    end
                end
                C_ADDR: begin
                    if (byte_valid) begin
                        addr   <= {addr[23:0], rx_shift};
                        to_cnt <= '0;
                        if (byte_cnt == 2'd3) begin
                            byte_cnt <= '0;
                            if (is_write) begin
                                cmd_state <= C_DATA;
                            end else begin
                                bus_req   <= 1'b1;
                                cmd_state <= C_REQ;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end else if (frame_err || to_cnt == TO_W'(TIMEOUT_CLKS - 1)) begin
                        cmd_state <= C_ERR;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                C_DATA: begin
                    if (byte_valid) begin
                        wdata  <= {wdata[23:0], rx_shift};
                        to_cnt <= '0;
                        if (byte_cnt == 2'd3) begin
                            byte_cnt  <= '0;
                            bus_req   <= 1'b1;
                            cmd_state <= C_REQ;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end else if (frame_err || to_cnt == TO_W'(TIMEOUT_CLKS - 1)) begin
                        cmd_state <= C_ERR;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                C_REQ: begin
                    if (bus_gnt) begin
                        rd        <= !is_write;
                        wr        <= is_write;
                        cmd_state <= C_ACCESS;
                    end
                end
                C_ACCESS: begin
                    rd        <= 1'b0;
                    wr        <= 1'b0;
                    bus_req   <= 1'b0;
                    cmd_state <= C_RESP;
                end
                C_ERR: begin
                    cmd_state <= C_RESP;
                end
                C_RESP: begin
                    if (tx_done_c) begin
                        busy      <= 1'b0;
                        cmd_state <= C_IDLE;
                    end
                end
                default: cmd_state <= C_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Randomized scoreboard bench for uart_bus_bridge with a byte/transaction-level model.
module tb_uart_bus_bridge;

    localparam int unsigned CPB = 16;
    localparam int unsigned TO  = 1000;

    typedef struct {
        bit          is_wr;
        logic [31:0] a;
        logic [31:0] d;
    } bus_op_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rxd = 1'b1;
    logic        txd;
    logic        bus_req;
    logic        bus_gnt;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;

    int          chk = 0;
    int          errs = 0;
    int          cyc = 0;
    int          req_cycles = 0;
    int          acc_cyc = 0;
    int          start_cyc = 0;
    bit          gnt_rand = 1'b0;
    bit          gnt_force = 1'b1;
    bit          gnt_rnd_val = 1'b0;

    logic [7:0]  exp_tx[$];
    bus_op_t     exp_bus[$];

    uart_bus_bridge #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
        .sysclk (clk),
        .reset  (reset),
        .rxd    (rxd),
        .txd    (txd),
        .bus_req(bus_req),
        .bus_gnt(bus_gnt),
        .rd     (rd),
        .wr     (wr),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Responder model: read data depends on address, only meaningful in the rd cycle.
    function automatic logic [31:0] model_rdata(input logic [31:0] a);
        if (a == 32'h4000_0010) return 32'h0000_003C;
        return {a[15:0] ^ 16'hBEEF, a[31:16]};
    endfunction

    assign rdata   = rd ? model_rdata(addr) : 32'hDEAD_BEEF;
    assign bus_gnt = gnt_rand ? gnt_rnd_val : gnt_force;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        gnt_rnd_val = ($urandom_range(0, 3) == 0);
        if (bus_req) req_cycles = req_cycles + 1;
    end

    task automatic do_check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bus monitor: every rd/wr beat must match the next expected transaction.
    bit prev_beat = 1'b0;
    always @(negedge clk) begin
        if (reset && (rd || wr)) begin
            bus_op_t op;
            acc_cyc = cyc;
            do_check("beat_width", 32'(prev_beat), 32'd0);
            do_check("beat_excl", 32'(rd & wr), 32'd0);
            do_check("beat_req", 32'(bus_req), 32'd1);
            chk++;
            if (exp_bus.size() == 0) begin
                errs++;
                $display("FAIL unexpected_beat: got rd=%b wr=%b addr=%h expected no beat", rd, wr, addr);
            end else begin
                op = exp_bus.pop_front();
                do_check("beat_type", 32'(wr), 32'(op.is_wr));
                do_check("beat_addr", addr, op.a);
                if (op.is_wr) do_check("beat_wdata", wdata, op.d);
            end
        end
        prev_beat = rd | wr;
    end

    // UART monitor on txd: decodes bytes and compares them with the expected reply stream.
    int         tm_st = 0;
    int         tm_cnt = 0;
    logic [7:0] tm_byte = 8'h00;
    always @(negedge clk) begin
        if (!reset) begin
            tm_st = 0;
        end else if (tm_st == 0) begin
            if (txd == 1'b0) begin
                tm_st = 1;
                tm_cnt = 0;
                start_cyc = cyc;
            end
        end else begin
            tm_cnt++;
            if (tm_cnt >= int'(CPB / 2 + CPB) && ((tm_cnt - int'(CPB / 2)) % int'(CPB)) == 0) begin
                if ((tm_cnt - int'(CPB / 2)) / int'(CPB) <= 8) begin
                    tm_byte = {txd, tm_byte[7:1]};
                end else begin
                    chk++;
                    if (exp_tx.size() == 0) begin
                        errs++;
                        $display("FAIL unexpected_tx_byte: got %h expected none", tm_byte);
                    end else begin
                        do_check("tx_byte", 32'(tm_byte), 32'(exp_tx.pop_front()));
                    end
                    do_check("tx_stop_bit", 32'(txd), 32'd1);
                    tm_st = 0;
                end
            end
        end
    end

    task automatic uart_send(input logic [7:0] b, input bit stop);
        @(negedge clk);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) begin
            logic [31:0] t;
            t = w >> (8 * i);
            uart_send(t[7:0], 1'b1);
        end
    endtask

    task automatic send_write(input logic [31:0] a, input logic [31:0] d);
        bus_op_t op;
        op.is_wr = 1'b1; op.a = a; op.d = d;
        exp_bus.push_back(op);
        exp_tx.push_back(8'h4B);
        uart_send(8'h57, 1'b1);
        do_check("busy_after_cmd", 32'(busy), 32'd1);
        send_word(a);
        send_word(d);
    endtask

    task automatic send_read(input logic [31:0] a);
        bus_op_t     op;
        logic [31:0] r;
        op.is_wr = 1'b0; op.a = a; op.d = 32'h0;
        exp_bus.push_back(op);
        r = model_rdata(a);
        exp_tx.push_back(r[31:24]);
        exp_tx.push_back(r[23:16]);
        exp_tx.push_back(r[15:8]);
        exp_tx.push_back(r[7:0]);
        uart_send(8'h52, 1'b1);
        do_check("busy_after_cmd", 32'(busy), 32'd1);
        send_word(a);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        do_check({name, "_busy_low"}, 32'(busy), 32'd0);
        do_check({name, "_tx_done"}, 32'(exp_tx.size()), 32'd0);
        do_check({name, "_bus_done"}, 32'(exp_bus.size()), 32'd0);
        do_check({name, "_txd_idle"}, 32'(txd), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0;
        int t0;
        int n;
        int bad;

        repeat (3) @(negedge clk);
        do_check("rst_txd", 32'(txd), 32'd1);
        do_check("rst_bus_req", 32'(bus_req), 32'd0);
        do_check("rst_rd", 32'(rd), 32'd0);
        do_check("rst_wr", 32'(wr), 32'd0);
        do_check("rst_addr", addr, 32'd0);
        do_check("rst_wdata", wdata, 32'd0);
        do_check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Directed write, reply starts the cycle after the wr beat.
        send_write(32'h4000_000C, 32'h0000_00A5);
        wait_idle("write");
        do_check("reply_latency", 32'(start_cyc - acc_cyc), 32'd1);
        do_check("addr_hold", addr, 32'h4000_000C);
        do_check("wdata_hold", wdata, 32'h0000_00A5);

        // Directed read.
        send_read(32'h4000_0010);
        wait_idle("read");

        // Grant withheld for 500 cycles.
        gnt_force = 1'b0;
        send_read(32'h1234_5678);
        n = 0;
        while (!bus_req && n < 1000) begin
            @(negedge clk);
            n++;
        end
        do_check("req_raised", 32'(bus_req), 32'd1);
        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if (!bus_req || rd) bad++;
        end
        do_check("req_hold_no_rd", 32'(bad), 32'd0);
        gnt_force = 1'b1;
        @(negedge clk);
        do_check("rd_after_gnt", 32'(rd), 32'd1);
        @(negedge clk);
        do_check("req_fall", 32'(bus_req), 32'd0);
        wait_idle("gnt_wait");

        // Unknown command.
        r0 = req_cycles;
        exp_tx.push_back(8'h3F);
        uart_send(8'h41, 1'b1);
        wait_idle("bad_cmd");
        do_check("bad_cmd_no_req", 32'(req_cycles - r0), 32'd0);

        // Inter-byte timeout inside an address field.
        r0 = req_cycles;
        exp_tx.push_back(8'h3F);
        uart_send(8'h57, 1'b1);
        uart_send(8'h11, 1'b1);
        uart_send(8'h22, 1'b1);
        t0 = cyc;
        wait_idle("timeout");
        do_check("timeout_elapsed", 32'((cyc - t0) >= int'(TO)), 32'd1);
        do_check("timeout_no_req", 32'(req_cycles - r0), 32'd0);

        // One-cycle glitch must not start a byte.
        @(negedge clk);
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        do_check("glitch_busy", 32'(busy), 32'd0);
        do_check("glitch_txd", 32'(txd), 32'd1);

        // Framing error during the address field.
        r0 = req_cycles;
        exp_tx.push_back(8'h3F);
        uart_send(8'h52, 1'b1);
        uart_send(8'h40, 1'b1);
        uart_send(8'h00, 1'b0);
        wait_idle("frame_err");
        do_check("frame_err_no_req", 32'(req_cycles - r0), 32'd0);

        // Randomized frames with a randomly toggling grant.
        gnt_rand = 1'b1;
        for (int i = 0; i < 12; i++) begin
            int unsigned k;
            k = $urandom_range(0, 9);
            if (k < 5) begin
                send_write($urandom, $urandom);
            end else if (k < 9) begin
                send_read($urandom);
            end else begin
                logic [7:0] b;
                b = 8'($urandom);
                if (b == 8'h57 || b == 8'h52) b = 8'h00;
                exp_tx.push_back(8'h3F);
                uart_send(b, 1'b1);
            end
            wait_idle("random");
        end
        gnt_rand = 1'b0;
        gnt_force = 1'b1;

        // Reset in the middle of a reply byte, then a normal read.
        send_read($urandom);
        n = 0;
        while (txd && n < 5000) begin
            @(negedge clk);
            n++;
        end
        do_check("reply_started", 32'(txd), 32'd0);
        repeat (2 * CPB + 3) @(negedge clk);
        reset = 1'b0;
        exp_tx.delete();
        exp_bus.delete();
        @(negedge clk);
        do_check("rst_mid_txd", 32'(txd), 32'd1);
        do_check("rst_mid_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        send_read(32'h4000_0010);
        wait_idle("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", chk, errs);
        $finish;
    end

endmodule
